// File: rtl/qtc_conv_sched.sv
// Round-robin scheduler sharing one sign-magnitude to two's-complement converter
// among NREQ requesters; one result per grant, tagged with the requester index.
module qtc_conv_sched #(
  parameter int unsigned N    = 32,
  parameter int unsigned Q    = 15,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*N-1:0]   req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                out_valid,
  output logic [2*N-1:0]      out_data,
  output logic [IDW-1:0]      out_id,
  input  logic                out_ready,
  output logic                busy,
  output logic [15:0]         conv_count
);

  localparam int unsigned OW = 2 * N;

  // Q only documents the fixed-point format; the conversion is bit-exact.
  if (NREQ < 2 || IDW != $clog2(NREQ) || Q >= N) begin : g_param_check
    $error("qtc_conv_sched: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [N-1:0]    word_q;
  logic [IDW-1:0]  win_c;
  logic [IDW-1:0]  idx_c;
  logic            found_c;
  logic            grant_c;
  logic [OW-1:0]   mag_c;
  logic [OW-1:0]   conv_c;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    idx_c   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx_c = IDW'((32'(rr_ptr) + i) % NREQ);
      if (!found_c && req_valid[idx_c]) begin
        found_c = 1'b1;
        win_c   = idx_c;
      end
    end
  end

  assign grant_c   = (state == IDLE) && !rst && found_c;
  assign req_ready = grant_c ? (NREQ'(1) << win_c) : '0;

  // Negation over the full output width so negative zero folds back to zero.
  assign mag_c  = OW'(word_q[N-2:0]);
  assign conv_c = word_q[N-1] ? (~mag_c + OW'(1)) : mag_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      word_q     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_id     <= '0;
      busy       <= 1'b0;
      conv_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_c) begin
            word_q <= req_data[win_c*N +: N];
            out_id <= win_c;
            rr_ptr <= (32'(win_c) == NREQ - 1) ? '0 : win_c + IDW'(1);
            busy   <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          out_data  <= conv_c;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            conv_count <= conv_count + 16'd1;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
